// File: rtl/selftest_monitor.sv
// Hardware self-test bookkeeping: counts checker strobes, enforces a RUN watchdog,
// then streams a three-byte verdict (status, pass count, fail count) over valid/ready.
module selftest_monitor #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CHECK_VALID,
  input  logic       CHECK_OK,
  input  logic       DONE,
  output logic       BUSY,
  output logic       ALL_OK,
  output logic       TIMED_OUT,
  output logic       EXIT_CODE,
  output logic       FINISHED,
  output logic [7:0] PASS_COUNT,
  output logic [7:0] FAIL_COUNT,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, REPORT, HALT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc;
  logic [1:0]    idx;
  logic          start_go, expire, hs;

  assign OUT_VALID = (state == REPORT);
  assign hs        = OUT_VALID && OUT_READY;
  assign BUSY      = (state == RUN) || (state == REPORT);
  assign FINISHED  = (state == HALT);
  assign EXIT_CODE = FINISHED && !ALL_OK;

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (START) begin
          start_go  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // DONE has priority over a coincident watchdog expiry
        if (DONE) begin
          state_nxt = REPORT;
        end else if (cyc == CYC_LAST) begin
          expire    = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (hs && idx == 2'd2) state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALL_OK     <= 1'b1;
      TIMED_OUT  <= 1'b0;
      PASS_COUNT <= 8'd0;
      FAIL_COUNT <= 8'd0;
      cyc        <= '0;
      idx        <= 2'd0;
    end else begin
      if (start_go) begin
        ALL_OK     <= 1'b1;
        TIMED_OUT  <= 1'b0;
        PASS_COUNT <= 8'd0;
        FAIL_COUNT <= 8'd0;
        cyc        <= '0;
        idx        <= 2'd0;
      end
      if (state == RUN) begin
        if (CHECK_VALID) begin
          if (CHECK_OK) begin
            if (PASS_COUNT != 8'hFF) PASS_COUNT <= PASS_COUNT + 8'd1;
          end else begin
            if (FAIL_COUNT != 8'hFF) FAIL_COUNT <= FAIL_COUNT + 8'd1;
            ALL_OK <= 1'b0;
          end
        end
        if (expire) begin
          TIMED_OUT <= 1'b1;
          ALL_OK    <= 1'b0;
        end else if (!DONE) begin
          cyc <= cyc + CW'(1);
        end
      end
      if (hs) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  // Byte mux reads only registers frozen during REPORT, so a stalled byte holds
  always_comb begin
    OUT_DATA = 8'h00;
    if (state == REPORT) begin
      case (idx)
        2'd0:    OUT_DATA = TIMED_OUT ? 8'h54 : (!ALL_OK ? 8'h46 : 8'h50);
        2'd1:    OUT_DATA = PASS_COUNT;
        default: OUT_DATA = FAIL_COUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_selftest_monitor.sv
// Randomized scoreboard bench for selftest_monitor: a run plan is turned into the
// expected verdict bytes by plain counting, and a negedge monitor checks the stream.
module tb_selftest_monitor;
  localparam int T = 300;

  logic       CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic       CHECK_VALID = 1'b0, CHECK_OK = 1'b0, DONE = 1'b0, OUT_READY = 1'b0;
  logic       BUSY, ALL_OK, TIMED_OUT, EXIT_CODE, FINISHED, OUT_VALID;
  logic [7:0] PASS_COUNT, FAIL_COUNT, OUT_DATA;

  selftest_monitor #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CHECK_VALID(CHECK_VALID), .CHECK_OK(CHECK_OK),
    .DONE(DONE), .BUSY(BUSY), .ALL_OK(ALL_OK), .TIMED_OUT(TIMED_OUT), .EXIT_CODE(EXIT_CODE),
    .FINISHED(FINISHED), .PASS_COUNT(PASS_COUNT), .FAIL_COUNT(FAIL_COUNT),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  int         n_chk = 0, n_pass = 0;
  logic [7:0] exp_q[$];
  bit         cv[T], ok[T];

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: pops one expected byte per handshake, checks hold while stalled
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge CLK) begin
    if (!RST && OUT_VALID) begin
      if (stalled) chk("stall_hold", OUT_DATA, held);
      if (OUT_READY) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
        else chk("out_byte", OUT_DATA, int'(exp_q.pop_front()));
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = OUT_DATA;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Reference: the run ends at DONE, or after T cycles if DONE never comes in time
  task automatic model(input int dcyc, output logic [7:0] st, output logic [7:0] pc,
                       output logic [7:0] fc, output bit to, output int end_k);
    int p = 0, f = 0;
    to    = !(dcyc >= 0 && dcyc < T);
    end_k = to ? T - 1 : dcyc;
    for (int k = 0; k <= end_k; k++)
      if (cv[k]) begin
        if (ok[k]) p++;
        else f++;
      end
    pc = (p > 255) ? 8'hFF : 8'(p);
    fc = (f > 255) ? 8'hFF : 8'(f);
    st = to ? 8'h54 : (f > 0 ? 8'h46 : 8'h50);
  endtask

  task automatic plan(input int pct_chk, input int pct_ok);
    for (int k = 0; k < T; k++) begin
      cv[k] = ($urandom_range(0, 99) < pct_chk);
      ok[k] = ($urandom_range(0, 99) < pct_ok);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_all_ok"}, ALL_OK, 1);
    chk({tag, "_timed_out"}, TIMED_OUT, 0);
    chk({tag, "_exit"}, EXIT_CODE, 0);
    chk({tag, "_finished"}, FINISHED, 0);
    chk({tag, "_counts"}, {PASS_COUNT, FAIL_COUNT}, 0);
    chk({tag, "_out"}, {OUT_VALID, OUT_DATA}, 0);
  endtask

  // rdy_rand: random OUT_READY in REPORT; abort: reset after a stalled REPORT
  task automatic do_run(input int dcyc, input bit rdy_rand, input bit abort);
    logic [7:0] st, pc, fc;
    bit         to;
    int         end_k, cycles;
    model(dcyc, st, pc, fc, to, end_k);
    if (!abort) begin
      exp_q.push_back(st);
      exp_q.push_back(pc);
      exp_q.push_back(fc);
    end
    // A failing check and DONE alongside START must both be ignored
    START = 1'b1; CHECK_VALID = 1'b1; CHECK_OK = 1'b0; DONE = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_after_start", BUSY, 1);
    chk("counts_cleared", {PASS_COUNT, FAIL_COUNT}, 0);
    chk("all_ok_on_start", ALL_OK, 1);
    chk("timed_out_cleared", TIMED_OUT, 0);
    for (int k = 0; k <= end_k; k++) begin
      CHECK_VALID = cv[k];
      CHECK_OK    = ok[k];
      DONE        = (k == dcyc);
      START       = (k == 1);
      if (k == end_k) chk("no_early_report", OUT_VALID, 0);
      @(posedge CLK); #1;
    end
    CHECK_VALID = 1'b0; DONE = 1'b0; START = 1'b0;
    chk("report_entry", OUT_VALID, 1);
    chk("timed_out_at_report", TIMED_OUT, to);
    chk("pass_count", PASS_COUNT, pc);
    chk("fail_count", FAIL_COUNT, fc);
    if (abort) begin
      repeat (2) begin @(posedge CLK); #1; end
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check_reset_state("abort");
      return;
    end
    cycles = 0;
    while (!FINISHED && cycles < 200) begin
      OUT_READY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge CLK); #1;
      cycles++;
    end
    OUT_READY = 1'b0;
    chk("finished", FINISHED, 1);
    if (!rdy_rand) chk("finish_latency", cycles, 3);
    chk("exit_code", EXIT_CODE, (st != 8'h50));
    chk("halt_all_ok", ALL_OK, (st == 8'h50));
    chk("halt_timed_out", TIMED_OUT, to);
    chk("halt_counts", {PASS_COUNT, FAIL_COUNT}, {pc, fc});
    chk("halt_idle_out", {BUSY, OUT_VALID}, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("reset");
    RST = 1'b0;
    // Three passes then DONE
    for (int k = 0; k < T; k++) begin cv[k] = 0; ok[k] = 0; end
    for (int k = 0; k < 3; k++) begin cv[k] = 1; ok[k] = 1; end
    do_run(5, 1'b0, 1'b0);
    // Two passes, one fail, DONE with a final pass
    for (int k = 0; k < T; k++) begin cv[k] = 0; ok[k] = 0; end
    cv[0] = 1; ok[0] = 1; cv[1] = 1; ok[1] = 1; cv[2] = 1; cv[3] = 1; ok[3] = 1;
    do_run(3, 1'b0, 1'b0);
    // Watchdog expiry, started from HALT after a failing run
    for (int k = 0; k < T; k++) begin cv[k] = 0; ok[k] = 0; end
    do_run(-1, 1'b0, 1'b0);
    // DONE on the last watchdog cycle; 300 passes saturate the count
    for (int k = 0; k < T; k++) begin cv[k] = 1; ok[k] = 1; end
    do_run(T - 1, 1'b0, 1'b0);
    // Mid-REPORT reset, then a fresh run from IDLE
    plan(60, 50);
    do_run(12, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      plan($urandom_range(20, 90), $urandom_range(60, 100));
      do_run(($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 60)), 1'b1, 1'b0);
    end
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
